// File: rtl/arp_pkg.sv
// Shared ARP receive constants and FSM state encodings.
// Field values follow the Ethernet/IPv4 ARP header layout.
package arp_pkg;

    localparam int          ARP_LEN    = 28;
    localparam logic [4:0]  LAST_BYTE  = 5'(ARP_LEN - 1);
    localparam logic [15:0] HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] PTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  HLEN       = 8'd6;
    localparam logic [7:0]  PLEN       = 8'd4;
    localparam logic [15:0] OPER_REQ   = 16'd1;
    localparam logic [15:0] OPER_REP   = 16'd2;

    typedef enum logic [3:0] {
        S_IDLE     = 4'b0001,
        S_REC_DATA = 4'b0010,
        S_CHECK    = 4'b0100,
        S_END      = 4'b1000
    } arp_state_t;

endpackage

// File: rtl/arp_rx.sv
// ARP payload receiver: captures the 28-byte ARP body, classifies it and
// emits one-cycle result pulses a fixed 30 cycles after the frame request.
module arp_rx
    import arp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] local_mac_addr,
    input  logic [31:0] local_ip_addr,
    input  logic        arp_rx_req,
    input  logic [7:0]  mac_rx_datain,
    output logic        arp_rx_end,
    output logic        arp_request_req,
    output logic        arp_found,
    output logic        arp_rx_err,
    output logic [47:0] arp_rec_source_mac_addr,
    output logic [31:0] arp_rec_source_ip_addr
);

    arp_state_t  r_state;
    arp_state_t  w_state_nxt;
    logic [4:0]  r_cnt;
    logic [15:0] r_htype;
    logic [15:0] r_ptype;
    logic [7:0]  r_hlen;
    logic [7:0]  r_plen;
    logic [15:0] r_oper;
    logic [47:0] r_sha;
    logic [31:0] r_spa;
    logic [47:0] r_tha;
    logic [31:0] r_tpa;
    logic        r_end;
    logic        r_req;
    logic        r_found;
    logic        r_err;
    logic [47:0] r_src_mac;
    logic [31:0] r_src_ip;

    logic        w_hdr_ok;
    logic        w_tgt_ok;
    logic        w_oper_ok;
    logic        w_eval;
    logic        w_req_p;
    logic        w_found_p;
    logic        w_err_p;
    logic        w_end_p;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a new request restarts reception from any state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (arp_rx_req) w_state_nxt = S_REC_DATA;
                else            w_state_nxt = S_IDLE;
            end
            S_REC_DATA: begin
                if (arp_rx_req)              w_state_nxt = S_REC_DATA;
                else if (r_cnt == LAST_BYTE) w_state_nxt = S_CHECK;
                else                         w_state_nxt = S_REC_DATA;
            end
            S_CHECK: begin
                if (arp_rx_req) w_state_nxt = S_REC_DATA;
                else            w_state_nxt = S_END;
            end
            S_END: begin
                if (arp_rx_req) w_state_nxt = S_REC_DATA;
                else            w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Frame classification, only meaningful while in CHECK
    always_comb begin
        w_hdr_ok  = (r_htype == HTYPE_ETH) && (r_ptype == PTYPE_IPV4) &&
                    (r_hlen == HLEN) && (r_plen == PLEN);
        w_tgt_ok  = (r_tpa == local_ip_addr);
        w_oper_ok = (r_oper == OPER_REQ) || (r_oper == OPER_REP);
        w_eval    = (r_state == S_CHECK) && !arp_rx_req;
        w_end_p   = w_eval;
        w_req_p   = w_eval && w_hdr_ok && w_tgt_ok && (r_oper == OPER_REQ);
        w_found_p = w_eval && w_hdr_ok && w_tgt_ok && (r_oper == OPER_REP);
        w_err_p   = w_eval && !(w_hdr_ok && w_oper_ok);
    end

    // Byte counter and field capture; multi-byte fields shift in MSB first
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= 5'd0;
            r_htype <= 16'd0;
            r_ptype <= 16'd0;
            r_hlen  <= 8'd0;
            r_plen  <= 8'd0;
            r_oper  <= 16'd0;
            r_sha   <= 48'd0;
            r_spa   <= 32'd0;
            r_tha   <= 48'd0;
            r_tpa   <= 32'd0;
        end else if (arp_rx_req || r_state != S_REC_DATA) begin
            r_cnt <= 5'd0;
        end else begin
            r_cnt <= (r_cnt == LAST_BYTE) ? 5'd0 : r_cnt + 5'd1;
            if (r_cnt <= 5'd1)       r_htype <= {r_htype[7:0], mac_rx_datain};
            else if (r_cnt <= 5'd3)  r_ptype <= {r_ptype[7:0], mac_rx_datain};
            else if (r_cnt == 5'd4)  r_hlen  <= mac_rx_datain;
            else if (r_cnt == 5'd5)  r_plen  <= mac_rx_datain;
            else if (r_cnt <= 5'd7)  r_oper  <= {r_oper[7:0], mac_rx_datain};
            else if (r_cnt <= 5'd13) r_sha   <= {r_sha[39:0], mac_rx_datain};
            else if (r_cnt <= 5'd17) r_spa   <= {r_spa[23:0], mac_rx_datain};
            else if (r_cnt <= 5'd23) r_tha   <= {r_tha[39:0], mac_rx_datain};
            else                     r_tpa   <= {r_tpa[23:0], mac_rx_datain};
        end
    end

    // Result pulses and sender latch, visible during the END cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_end     <= 1'b0;
            r_req     <= 1'b0;
            r_found   <= 1'b0;
            r_err     <= 1'b0;
            r_src_mac <= 48'd0;
            r_src_ip  <= 32'd0;
        end else begin
            r_end   <= w_end_p;
            r_req   <= w_req_p;
            r_found <= w_found_p;
            r_err   <= w_err_p;
            if (w_req_p || w_found_p) begin
                r_src_mac <= r_sha;
                r_src_ip  <= r_spa;
            end
        end
    end

    assign arp_rx_end              = r_end;
    assign arp_request_req         = r_req;
    assign arp_found               = r_found;
    assign arp_rx_err              = r_err;
    assign arp_rec_source_mac_addr = r_src_mac;
    assign arp_rec_source_ip_addr  = r_src_ip;

endmodule

// File: tb/tb_arp_rx.sv
// Directed bench for arp_rx: hand-built ARP frames with hand-computed
// outcomes, checked on the falling edge around the fixed END cycle.
module tb_arp_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] local_mac = 48'h000a3501fec0;
    logic [31:0] local_ip  = 32'hc0a80002;
    logic        req = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        w_end;
    logic        w_req;
    logic        w_found;
    logic        w_err;
    logic [47:0] w_mac;
    logic [31:0] w_ip;

    int checks = 0;
    int errors = 0;
    int end_total = 0;
    int pulse_total = 0;
    logic [7:0] frame [0:27];

    arp_rx u_dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .local_mac_addr          (local_mac),
        .local_ip_addr           (local_ip),
        .arp_rx_req              (req),
        .mac_rx_datain           (din),
        .arp_rx_end              (w_end),
        .arp_request_req         (w_req),
        .arp_found               (w_found),
        .arp_rx_err              (w_err),
        .arp_rec_source_mac_addr (w_mac),
        .arp_rec_source_ip_addr  (w_ip)
    );

    always #5 clk = ~clk;

    // Running tally of pulses seen, used to prove absence of spurious pulses
    always @(negedge clk) begin
        if (w_end) end_total++;
        if (w_req || w_found || w_err) pulse_total++;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic build(input logic [15:0] htype, input logic [15:0] ptype,
                         input logic [7:0] hlen, input logic [7:0] plen,
                         input logic [15:0] oper, input logic [47:0] sha,
                         input logic [31:0] spa, input logic [31:0] tpa);
        frame[0] = htype[15:8];
        frame[1] = htype[7:0];
        frame[2] = ptype[15:8];
        frame[3] = ptype[7:0];
        frame[4] = hlen;
        frame[5] = plen;
        frame[6] = oper[15:8];
        frame[7] = oper[7:0];
        for (int i = 0; i < 6; i++) frame[8 + i]  = sha[47 - 8*i -: 8];
        for (int i = 0; i < 4; i++) frame[14 + i] = spa[31 - 8*i -: 8];
        for (int i = 0; i < 6; i++) frame[18 + i] = local_mac[47 - 8*i -: 8];
        for (int i = 0; i < 4; i++) frame[24 + i] = tpa[31 - 8*i -: 8];
    endtask

    task automatic send_req();
        @(posedge clk);
        #1 req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic drive(input int n);
        for (int i = 0; i < n; i++) begin
            din = frame[i];
            @(posedge clk);
            #1;
        end
        din = 8'h00;
    endtask

    // Called right after the last byte edge: CHECK cycle, END cycle, idle cycle
    task automatic check_tail(input string tag, input int base_end, input int base_p,
                              input logic e_req, input logic e_found, input logic e_err,
                              input logic [47:0] e_mac, input logic [31:0] e_ip);
        @(negedge clk);
        check({tag, "/quiet_before"}, {w_end, w_req, w_found, w_err}, 4'b0000);
        @(negedge clk);
        check({tag, "/end"},   w_end,   1'b1);
        check({tag, "/req"},   w_req,   e_req);
        check({tag, "/found"}, w_found, e_found);
        check({tag, "/err"},   w_err,   e_err);
        check({tag, "/mac"},   w_mac,   e_mac);
        check({tag, "/ip"},    w_ip,    e_ip);
        @(negedge clk);
        check({tag, "/quiet_after"}, {w_end, w_req, w_found, w_err}, 4'b0000);
        check({tag, "/end_count"},   end_total - base_end, 1);
        check({tag, "/pulse_count"}, pulse_total - base_p, int'(e_req) + int'(e_found) + int'(e_err));
    endtask

    task automatic run_frame(input string tag, input logic e_req, input logic e_found,
                             input logic e_err, input logic [47:0] e_mac, input logic [31:0] e_ip);
        int be;
        int bp;
        be = end_total;
        bp = pulse_total;
        send_req();
        drive(28);
        check_tail(tag, be, bp, e_req, e_found, e_err, e_mac, e_ip);
    endtask

    initial begin
        int be;
        int bp;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset/pulses", {w_end, w_req, w_found, w_err}, 4'b0000);
        check("reset/mac", w_mac, 48'h0);
        check("reset/ip",  w_ip,  32'h0);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        build(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1, 48'h0123456789ab, 32'hc0a80003, 32'hc0a80002);
        run_frame("request", 1'b1, 1'b0, 1'b0, 48'h0123456789ab, 32'hc0a80003);

        build(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd2, 48'h0a0b0c0d0e0f, 32'hc0a80004, 32'hc0a80002);
        run_frame("reply", 1'b0, 1'b1, 1'b0, 48'h0a0b0c0d0e0f, 32'hc0a80004);

        build(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1, 48'h112233445566, 32'hc0a80005, 32'hc0a80009);
        run_frame("tpa_miss", 1'b0, 1'b0, 1'b0, 48'h0a0b0c0d0e0f, 32'hc0a80004);

        build(16'h0006, 16'h0800, 8'd6, 8'd4, 16'd1, 48'h112233445566, 32'hc0a80005, 32'hc0a80002);
        run_frame("bad_htype", 1'b0, 1'b0, 1'b1, 48'h0a0b0c0d0e0f, 32'hc0a80004);

        build(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd3, 48'h112233445566, 32'hc0a80005, 32'hc0a80002);
        run_frame("oper3", 1'b0, 1'b0, 1'b1, 48'h0a0b0c0d0e0f, 32'hc0a80004);

        build(16'h0001, 16'h0800, 8'd5, 8'd4, 16'd2, 48'h112233445566, 32'hc0a80005, 32'hc0a80002);
        run_frame("bad_hlen", 1'b0, 1'b0, 1'b1, 48'h0a0b0c0d0e0f, 32'hc0a80004);

        build(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd3, 48'h112233445566, 32'hc0a80005, 32'hc0a80009);
        run_frame("oper3_tpa_miss", 1'b0, 1'b0, 1'b1, 48'h0a0b0c0d0e0f, 32'hc0a80004);

        // Second request arrives where byte 10 of the first frame would be
        build(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1, 48'h2468ace01357, 32'hc0a80006, 32'hc0a80002);
        be = end_total;
        bp = pulse_total;
        send_req();
        drive(10);
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        drive(28);
        check_tail("abort", be, bp, 1'b1, 1'b0, 1'b0, 48'h2468ace01357, 32'hc0a80006);

        // Reset pulse at byte 15 discards the frame
        be = end_total;
        bp = pulse_total;
        send_req();
        drive(15);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (35) @(posedge clk);
        @(negedge clk);
        check("midreset/end_count",   end_total - be, 0);
        check("midreset/pulse_count", pulse_total - bp, 0);
        check("midreset/mac", w_mac, 48'h0);
        check("midreset/ip",  w_ip,  32'h0);

        build(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1, 48'h0123456789ab, 32'hc0a80003, 32'hc0a80002);
        run_frame("after_reset", 1'b1, 1'b0, 1'b0, 48'h0123456789ab, 32'hc0a80003);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arp_rx.md
ARP_RX -- requirements
Module: arp_rx

Interface
REQ-001 Parameters: none; ARP field constants live in the shared package.
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 local_mac_addr  in  48  own MAC, quasi-static.
REQ-005 local_ip_addr  in  32  own IPv4 address, quasi-static.
REQ-006 arp_rx_req  in  1  one-cycle pulse from the MAC receiver: frame type 0x0806 identified.
REQ-007 mac_rx_datain  in  8  MAC payload bytes, one per cycle; ARP byte 0 arrives in the cycle after arp_rx_req.
REQ-008 arp_rx_end  out  1  one-cycle pulse: ARP payload fully consumed; the MAC receiver moves to CRC check on it.
REQ-009 arp_request_req  out  1  one-cycle pulse: valid ARP request targeting local_ip_addr.
REQ-010 arp_found  out  1  one-cycle pulse: valid ARP reply targeting local_ip_addr.
REQ-011 arp_rx_err  out  1  one-cycle pulse: header mismatch or unsupported opcode.
REQ-012 arp_rec_source_mac_addr  out  48  sender MAC of the last valid frame.
REQ-013 arp_rec_source_ip_addr  out  32  sender IP of the last valid frame.

Function
REQ-014 Payload layout, byte index 0..27: HTYPE[0:1], PTYPE[2:3], HLEN[4], PLEN[5], OPER[6:7], SHA[8:13], SPA[14:17], THA[18:23], TPA[24:27]; big-endian, MSB first.
REQ-015 FSM states: IDLE, REC_DATA, CHECK, END; one-hot encoded.
REQ-016 IDLE -> REC_DATA on arp_rx_req; byte counter (5 bits) cleared to 0.
REQ-017 REC_DATA: sample mac_rx_datain every cycle into the field selected by the counter; increment counter; -> CHECK after byte 27 is sampled.
REQ-018 CHECK: evaluate the frame; register all result pulses; -> END.
REQ-019 END: result pulses high for exactly this cycle; -> IDLE.
REQ-020 Byte k is sampled in cycle req+1+k; arp_rx_end asserts in cycle req+30; the total latency from the req pulse is fixed at 30 cycles.
REQ-021 Header valid when HTYPE=0x0001, PTYPE=0x0800, HLEN=6, PLEN=4.
REQ-022 Target match when TPA == local_ip_addr; THA is captured but not checked.
REQ-023 Valid header, target match, OPER=1 -> arp_request_req.
REQ-024 Valid header, target match, OPER=2 -> arp_found.
REQ-025 Invalid header, or OPER not in {1,2} -> arp_rx_err; neither request nor found.
REQ-026 Valid header with TPA mismatch -> silent drop; arp_rx_end only.
REQ-027 arp_rx_end pulses at the end of every frame, whatever the outcome.
REQ-028 Source outputs update only in the END cycle of a frame that asserts arp_request_req or arp_found; they hold otherwise.
REQ-029 At most one of arp_request_req, arp_found and arp_rx_err is high in any cycle.
REQ-030 arp_rx_req arriving during REC_DATA, CHECK or END: abort the current frame without pulses, clear the counter and restart in REC_DATA; the new frame's byte 0 is taken from the next cycle.
REQ-031 Counter never exceeds 27; no wrap is possible.

Reset
REQ-032 rst_n low at any clock edge: state IDLE, counter 0, all pulses 0, source MAC/IP 0, captured fields 0.
REQ-033 Reset during a frame discards it; no pulse is emitted for that frame after release.

Structure
REQ-034 Shared package arp_pkg: ARP_LEN=28, HTYPE_ETH=0x0001, PTYPE_IPV4=0x0800, HLEN=6, PLEN=4, OPER_REQ=1, OPER_REP=2, state encodings.
REQ-035 Single flat module; no sub-module.

Verification
REQ-036 local 00:0a:35:01:fe:c0 / c0a80002; request from 01:23:45:67:89:ab / c0a80003 -> cycle req+30: arp_rx_end=1, arp_request_req=1, src mac 0123456789ab, src ip c0a80003.
REQ-037 Same fields, OPER=2 -> arp_found=1, arp_rx_end=1, sources updated.
REQ-038 Request with TPA=c0a80009 -> arp_rx_end=1 only; sources keep previous values.
REQ-039 HTYPE=0x0006 or OPER=3 -> arp_rx_err=1, arp_rx_end=1, no request/found.
REQ-040 Second arp_rx_req at byte 10 -> first frame yields no pulses; second frame completes 30 cycles after the second req.
REQ-041 rst_n low at byte 15 for 1 cycle -> no pulses; all outputs 0; next frame decodes normally.
